signed_lt_share_arbiter: RTL and testbench

- Shares one 32-bit signed less-than comparator among NREQ requesters.
- Round-robin arbitration selects at most one request per cycle.
- The comparator result is registered, so each response appears one cycle after its grant, tagged with the requester index.
- A single output register with valid/ready backpressure stalls arbitration while a response is unaccepted.

---
 rtl/signed_lt_share_arbiter_pkg.sv | 47 ++++
 rtl/signed_lt_share_arbiter_if.sv | 26 ++
 rtl/signed_lt_share_arbiter_core.sv | 13 +
 rtl/signed_lt_share_arbiter.sv | 84 ++++++++
 tb/tb_signed_lt_share_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_lt_share_arbiter_pkg.sv
// Shared definitions for the signed less-than sharing arbiter: default sizes,
// FSM state encoding and the round-robin next-index search.
package signed_lt_pkg;

    localparam int DEF_W    = 32;
    localparam int DEF_NREQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } arb_state_e;

    // Result of a round-robin search; idx is meaningful only when found=1.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Rotate req so that ptr sits at position 0, priority-encode the lowest
    // set bit, then unrotate that position back to a requester index.
    // Sized for up to 16 requesters; n is the live requester count.
    function automatic rr_pick_t rr_next(input logic [15:0] req,
                                         input logic [4:0]  n,
                                         input logic [3:0]  ptr);
        logic [15:0] rot;
        logic [4:0]  pos;
        rr_pick_t    r;
        rot = '0;
        r   = '0;
        for (int k = 0; k < 16; k++) begin
            pos = 5'(ptr) + 5'(k);
            if (pos >= n) pos = pos - n;
            if (5'(k) < n) rot[k] = req[pos[3:0]];
        end
        // Walk downward so the lowest rotated position wins.
        for (int k = 15; k >= 0; k--) begin
            if (rot[k]) begin
                pos = 5'(ptr) + 5'(k);
                if (pos >= n) pos = pos - n;
                r.found = 1'b1;
                r.idx   = pos[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_lt_share_arbiter_if.sv
// Requester / response bundle for the shared signed comparator. The master
// side presents requests and consumes responses; the slave side is the arbiter.
interface signed_lt_share_arbiter_if import signed_lt_pkg::*; #(
    parameter int W    = DEF_W,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_flat;
    logic [NREQ*W-1:0] b_flat;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_lt;
    logic              rsp_ready;

    modport master (
        output req, a_flat, b_flat, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_lt
    );

    modport slave (
        input  req, a_flat, b_flat, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_lt
    );
endinterface

// File: rtl/signed_lt_share_arbiter_core.sv
// Purely combinational W-bit two's complement less-than. Kept as its own
// module so it can be replaced by an optimised gate-level netlist.
module signed_lt_core #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
    // Differing signs: a is smaller exactly when it is the negative one.
    // Equal signs: the magnitude bits order the same way as the values.
    assign lt = (a[W-1] != b[W-1]) ? a[W-1] : (a[W-2:0] < b[W-2:0]);
endmodule

// File: rtl/signed_lt_share_arbiter.sv
// Round-robin arbiter sharing one signed less-than comparator among NREQ
// requesters, with a single registered response slot and valid/ready output.
module signed_lt_share_arbiter import signed_lt_pkg::*; #(
    parameter int W    = DEF_W,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic                      clk,
    input logic                      rst_n,
    signed_lt_share_arbiter_if.slave bus
);
    arb_state_e     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_lt_q;

    logic           can_issue;
    rr_pick_t       pick;
    logic [NREQ-1:0] gnt;
    logic           granted;
    logic [IDW-1:0] ptr_next;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           core_lt;

    // The slot can take a new result when empty or being drained this cycle.
    assign can_issue = (state == ST_IDLE) || bus.rsp_ready;
    assign pick      = rr_next(16'(bus.req), 5'(NREQ), 4'(rr_ptr));
    assign granted   = |gnt;
    assign ptr_next  = (pick.idx == 4'(NREQ - 1)) ? '0 : IDW'(pick.idx + 4'd1);

    // One-hot grant, forced low while reset is asserted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt = '0;
        if (rst_n && can_issue && pick.found) gnt[pick.idx[IDW-1:0]] = 1'b1;
    end

    // One-hot AND-OR operand mux feeding the single comparator.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = sel_a | bus.a_flat[i*W +: W];
                sel_b = sel_b | bus.b_flat[i*W +: W];
            end
        end
    end

    signed_lt_core #(.W(W)) u_core (
        .a  (sel_a),
        .b  (sel_b),
        .lt (core_lt)
    );

    // Response slot FSM with registered id/result and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            rsp_id_q <= '0;
            rsp_lt_q <= 1'b0;
        end else begin
            if (granted) begin
                rsp_id_q <= IDW'(pick.idx);
                rsp_lt_q <= core_lt;
                rr_ptr   <= ptr_next;
            end
            case (state)
                ST_IDLE: if (granted) state <= ST_FULL;
                ST_FULL: if (!granted && bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = (state == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_lt    = rsp_lt_q;

endmodule

// File: tb/tb_signed_lt_share_arbiter.sv
// Scoreboard bench for signed_lt_share_arbiter: the driver pushes the expected
// response when it predicts a grant; the monitor pops on every accepted response.
module tb_signed_lt_share_arbiter;
    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic           lt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic exp_lt_tab [NREQ];

    signed_lt_share_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

    signed_lt_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic lt);
        bus.a_flat[i*W +: W] = a;
        bus.b_flat[i*W +: W] = b;
        exp_lt_tab[i]        = lt;
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock: drive at posedge+1, check grant/valid at negedge, push expected.
    task automatic cycle(input logic [NREQ-1:0] r, input logic rdy,
                         input logic [NREQ-1:0] eg, input logic ev, input string tag);
        bus.req       = r;
        bus.rsp_ready = rdy;
        @(negedge clk);
        check({tag, "_gnt"}, 64'(bus.gnt), 64'(eg));
        check({tag, "_valid"}, 64'(bus.rsp_valid), 64'(ev));
        if (eg != '0) exp_q.push_back('{id: IDW'(oh_idx(eg)), lt: exp_lt_tab[oh_idx(eg)]});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted response must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
                check("rsp_lt", 64'(bus.rsp_lt), 64'(mon_e.lt));
            end
        end
    end

    initial begin
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] pg;
        logic [W-1:0]    a_r, b_r;
        logic            rdy;
        logic            valid_m;
        int              ptr_m, gi, j;
        int              wait_cnt [NREQ];

        bus.req       = 4'b0001;
        bus.rsp_ready = 1'b1;
        bus.a_flat    = '0;
        bus.b_flat    = '0;
        for (int i = 0; i < NREQ; i++) exp_lt_tab[i] = 1'b0;

        // Reset state, with a request present to prove gnt is held low.
        #3;
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_id", 64'(bus.rsp_id), 64'd0);
        check("rst_lt", 64'(bus.rsp_lt), 64'd0);
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        bus.req = '0;
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester: -1 < 0.
        set_ops(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        cycle(4'b0001, 1'b1, 4'b0001, 1'b0, "single");
        cycle(4'b0000, 1'b1, 4'b0000, 1'b1, "single_rsp");

        // Sign corners on requester 2 (pointer is 1, then 3).
        set_ops(2, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        cycle(4'b0100, 1'b1, 4'b0100, 1'b0, "c_min_max");
        set_ops(2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        cycle(4'b0100, 1'b1, 4'b0100, 1'b1, "c_max_min");
        set_ops(2, 32'h1234_5678, 32'h1234_5678, 1'b0);
        cycle(4'b0100, 1'b1, 4'b0100, 1'b1, "c_equal");
        cycle(4'b0000, 1'b1, 4'b0000, 1'b1, "c_drain");

        // Rotation: bring pointer to 0, then all four held for 8 cycles.
        set_ops(0, 32'h0000_0005, 32'h0000_0007, 1'b1);
        set_ops(1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0);
        set_ops(2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        set_ops(3, 32'hFFFF_FF00, 32'h0000_0100, 1'b1);
        cycle(4'b1000, 1'b1, 4'b1000, 1'b0, "rot_pre");
        for (int k = 0; k < 8; k++) begin
            pg = 4'b0001 << (k % 4);
            cycle(4'b1111, 1'b1, pg, 1'b1, "rot");
        end

        // Backpressure: response from 0 held for 3 cycles, then accept+grant 1.
        cycle(4'b1111, 1'b1, 4'b0001, 1'b1, "bp_grant");
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, 4'b0000, 1'b1, "bp_stall");
            check("bp_id", 64'(bus.rsp_id), 64'd0);
            check("bp_lt", 64'(bus.rsp_lt), 64'd1);
        end
        cycle(4'b1111, 1'b1, 4'b0010, 1'b1, "bp_release");
        cycle(4'b0000, 1'b1, 4'b0000, 1'b1, "bp_drain");

        // Reset mid-stall: response from 2 pending, pointer at 3.
        set_ops(2, 32'h8000_0000, 32'h0000_0000, 1'b1);
        cycle(4'b0100, 1'b0, 4'b0100, 1'b0, "rs_grant");
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "rs_stall");
        bus.req = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        check("rs_valid", 64'(bus.rsp_valid), 64'd0);
        check("rs_id", 64'(bus.rsp_id), 64'd0);
        check("rs_lt", 64'(bus.rsp_lt), 64'd0);
        check("rs_gnt", 64'(bus.gnt), 64'd0);
        exp_q.delete();
        bus.req = '0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(4'b1100, 1'b1, 4'b0100, 1'b0, "rs_after");
        cycle(4'b0000, 1'b1, 4'b0000, 1'b1, "rs_drain");

        // Random traffic with a bench-side arbitration model (pointer at 3).
        ptr_m   = 3;
        valid_m = 1'b0;
        pend    = '0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    a_r     = $urandom;
                    case ($urandom_range(0, 3))
                        0:       b_r = a_r;
                        1:       b_r = ~a_r;
                        2:       b_r = 32'h8000_0000;
                        default: b_r = $urandom;
                    endcase
                    set_ops(i, a_r, b_r, $signed(a_r) < $signed(b_r));
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            pg  = '0;
            if (!valid_m || rdy) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (ptr_m + k) % NREQ;
                    if (pg == '0 && pend[j]) pg[j] = 1'b1;
                end
            end
            cycle(pend, rdy, pg, valid_m, "rnd");
            if (pg != '0) begin
                gi = oh_idx(pg);
                check("rnd_starve", 64'(wait_cnt[gi] <= NREQ - 1), 64'd1);
                for (int i = 0; i < NREQ; i++) if (pend[i] && i != gi) wait_cnt[i]++;
                wait_cnt[gi] = 0;
                pend[gi]     = 1'b0;
                ptr_m        = (gi + 1) % NREQ;
                valid_m      = 1'b1;
            end else if (rdy) begin
                valid_m = 1'b0;
            end
        end

        // Drain and confirm every granted request produced its response.
        bus.req       = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("q_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
